// File: rtl/sne_pkg.sv
// Shared op-code constants and scheduler state encoding for the event engine.
package sne_pkg;

    // dp_operation codes mirrored from evt_neuron_defines; every other code is a spike.
    localparam logic [1:0] RST_OP    = 2'b10;
    localparam logic [1:0] UPDATE_OP = 2'b11;

    typedef enum logic [2:0] {
        ST_PASS   = 3'd0,
        ST_DRAIN  = 3'd1,
        ST_ISSUE  = 3'd2,
        ST_SWEEP  = 3'd3,
        ST_ONLINE = 3'd4
    } sched_state_e;

    function automatic logic is_sweep_op(input logic [1:0] op);
        return (op == RST_OP) || (op == UPDATE_OP);
    endfunction

endpackage

// File: rtl/evt_inflight_counter.sv
// Saturating up/down count of spikes accepted but not yet retired, with a sticky underflow flag.
module evt_inflight_counter #(
    parameter int unsigned MAX_COUNT = 8,
    parameter int unsigned CW        = $clog2(MAX_COUNT + 1)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          inc_i,
    input  logic          dec_i,
    output logic [CW-1:0] count_o,
    output logic          full_o,
    output logic          zero_o,
    output logic          underflow_o
);

    localparam logic [CW-1:0] MAX_C = CW'(MAX_COUNT);

    logic [CW-1:0] count_q, count_d;
    logic          underflow_q, underflow_d;
    logic          inc_ok, dec_ok;

    assign zero_o      = (count_q == '0);
    assign full_o      = (count_q >= MAX_C);
    assign count_o     = count_q;
    assign underflow_o = underflow_q;

    always_comb begin
        count_d     = count_q;
        underflow_d = underflow_q;
        // A retire with nothing outstanding is dropped but remembered.
        dec_ok      = dec_i & ~zero_o;
        inc_ok      = inc_i & ~full_o;
        if (inc_ok && !dec_ok) begin
            count_d = count_q + CW'(1);
        end else if (dec_ok && !inc_ok) begin
            count_d = count_q - CW'(1);
        end
        if (dec_i && zero_o) begin
            underflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q     <= '0;
            underflow_q <= 1'b0;
        end else begin
            count_q     <= count_d;
            underflow_q <= underflow_d;
        end
    end

endmodule

// File: rtl/evt_engine_op_scheduler.sv
// Orders pass-through spike events against memory sweeps (RST/UPDATE) and grants
// online register access only while the engine is idle.
module evt_engine_op_scheduler
    import sne_pkg::*;
#(
    parameter int unsigned MAX_INFLIGHT    = 8,
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned SPIKE_CNT_WIDTH = 32,
    parameter int unsigned SWEEP_CNT_WIDTH = 16
) (
    input  logic                               engine_clk_i,
    input  logic                               engine_rst_ni,
    input  logic                               evt_valid_i,
    output logic                               evt_ready_o,
    input  logic [1:0]                         evt_op_i,
    input  logic [DATA_WIDTH-1:0]              evt_data_i,
    output logic                               seq_valid_o,
    input  logic                               seq_ready_i,
    output logic [DATA_WIDTH-1:0]              seq_data_o,
    input  logic                               spike_done_i,
    input  logic                               sweep_done_i,
    input  logic                               time_stable_i,
    input  logic                               online_req_i,
    output logic                               online_gnt_o,
    input  logic                               clear_cnt_i,
    output logic [$clog2(MAX_INFLIGHT+1)-1:0]  inflight_o,
    output logic [SPIKE_CNT_WIDTH-1:0]         spike_cnt_o,
    output logic [SWEEP_CNT_WIDTH-1:0]         sweep_cnt_o,
    output logic                               err_underflow_o
);

    localparam int unsigned INFL_W = $clog2(MAX_INFLIGHT + 1);

    sched_state_e state_q, state_d;
    logic         gnt_q;
    logic [SPIKE_CNT_WIDTH-1:0] spike_cnt_q, spike_cnt_d;
    logic [SWEEP_CNT_WIDTH-1:0] sweep_cnt_q, sweep_cnt_d;

    logic evt_is_sweep;
    logic spike_hs;
    logic sweep_fin;
    logic infl_full, infl_zero;
    logic seq_valid, evt_ready;

    assign evt_is_sweep = is_sweep_op(evt_op_i);

    evt_inflight_counter #(
        .MAX_COUNT (MAX_INFLIGHT),
        .CW        (INFL_W)
    ) u_inflight (
        .clk_i       (engine_clk_i),
        .rst_ni      (engine_rst_ni),
        .inc_i       (spike_hs),
        .dec_i       (spike_done_i),
        .count_o     (inflight_o),
        .full_o      (infl_full),
        .zero_o      (infl_zero),
        .underflow_o (err_underflow_o)
    );

    always_comb begin
        state_d   = state_q;
        seq_valid = 1'b0;
        evt_ready = 1'b0;
        spike_hs  = 1'b0;
        sweep_fin = 1'b0;
        unique case (state_q)
            ST_PASS: begin
                if (evt_valid_i && evt_is_sweep) begin
                    state_d = ST_DRAIN;
                end else begin
                    // Full is judged on the registered count, so a same-cycle retire unblocks next cycle.
                    if (evt_valid_i && !infl_full && !online_req_i) begin
                        seq_valid = 1'b1;
                        evt_ready = seq_ready_i;
                        spike_hs  = seq_ready_i;
                    end
                    if (online_req_i && infl_zero) begin
                        state_d = ST_ONLINE;
                    end
                end
            end
            ST_DRAIN: begin
                if (infl_zero && time_stable_i) begin
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                // Upstream still holds the sweep event, so its payload goes straight through.
                seq_valid = 1'b1;
                evt_ready = seq_ready_i;
                if (seq_ready_i) begin
                    state_d = ST_SWEEP;
                end
            end
            ST_SWEEP: begin
                if (sweep_done_i) begin
                    sweep_fin = 1'b1;
                    state_d   = ST_PASS;
                end
            end
            ST_ONLINE: begin
                if (!online_req_i) begin
                    state_d = ST_PASS;
                end
            end
            default: state_d = ST_PASS;
        endcase
    end

    always_comb begin
        spike_cnt_d = spike_cnt_q;
        sweep_cnt_d = sweep_cnt_q;
        if (clear_cnt_i) begin
            spike_cnt_d = '0;
            sweep_cnt_d = '0;
        end else begin
            if (spike_hs) begin
                spike_cnt_d = spike_cnt_q + SPIKE_CNT_WIDTH'(1);
            end
            if (sweep_fin) begin
                sweep_cnt_d = sweep_cnt_q + SWEEP_CNT_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge engine_clk_i or negedge engine_rst_ni) begin
        if (!engine_rst_ni) begin
            state_q     <= ST_PASS;
            gnt_q       <= 1'b0;
            spike_cnt_q <= '0;
            sweep_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= (state_d == ST_ONLINE);
            spike_cnt_q <= spike_cnt_d;
            sweep_cnt_q <= sweep_cnt_d;
        end
    end

    assign seq_valid_o  = seq_valid;
    assign evt_ready_o  = evt_ready;
    assign seq_data_o   = evt_data_i;
    assign online_gnt_o = gnt_q;
    assign spike_cnt_o  = spike_cnt_q;
    assign sweep_cnt_o  = sweep_cnt_q;

endmodule

// File: tb/tb_evt_engine_op_scheduler.sv
// Self-checking bench: vector table for spike flow control, scripted sweep/online/reset
// sequences, and a payload scoreboard checked on every downstream transfer.
module tb_evt_engine_op_scheduler;
    import sne_pkg::*;

    localparam int unsigned MAXI = 2;
    localparam int unsigned DW   = 32;

    logic           clk;
    logic           rst_n;
    logic           evt_valid;
    logic           evt_ready;
    logic [1:0]     evt_op;
    logic [DW-1:0]  evt_data;
    logic           seq_valid;
    logic           seq_ready;
    logic [DW-1:0]  seq_data;
    logic           spike_done;
    logic           sweep_done;
    logic           time_stable;
    logic           online_req;
    logic           online_gnt;
    logic           clear_cnt;
    logic [1:0]     inflight;
    logic [31:0]    spike_cnt;
    logic [15:0]    sweep_cnt;
    logic           err_uf;

    int n_checks = 0;
    int n_errors = 0;
    logic [DW-1:0] sb[$];
    logic [DW-1:0] sb_exp;

    evt_engine_op_scheduler #(
        .MAX_INFLIGHT    (MAXI),
        .DATA_WIDTH      (DW),
        .SPIKE_CNT_WIDTH (32),
        .SWEEP_CNT_WIDTH (16)
    ) dut (
        .engine_clk_i    (clk),
        .engine_rst_ni   (rst_n),
        .evt_valid_i     (evt_valid),
        .evt_ready_o     (evt_ready),
        .evt_op_i        (evt_op),
        .evt_data_i      (evt_data),
        .seq_valid_o     (seq_valid),
        .seq_ready_i     (seq_ready),
        .seq_data_o      (seq_data),
        .spike_done_i    (spike_done),
        .sweep_done_i    (sweep_done),
        .time_stable_i   (time_stable),
        .online_req_i    (online_req),
        .online_gnt_o    (online_gnt),
        .clear_cnt_i     (clear_cnt),
        .inflight_o      (inflight),
        .spike_cnt_o     (spike_cnt),
        .sweep_cnt_o     (sweep_cnt),
        .err_underflow_o (err_uf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] op, input logic [DW-1:0] d,
                         input logic sr, input logic dn);
        evt_valid  = v;
        evt_op     = op;
        evt_data   = d;
        seq_ready  = sr;
        spike_done = dn;
    endtask

    // Scoreboard: every downstream transfer must match the oldest expected payload.
    always @(negedge clk) begin
        if (rst_n && seq_valid && seq_ready) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL sb_unexpected: got transfer data=%08h, expected none", seq_data);
            end else begin
                sb_exp = sb.pop_front();
                $display("xfer data=%08h expected=%08h", seq_data, sb_exp);
                check("sb_data", 64'(seq_data), 64'(sb_exp));
                check("sb_evt_ready", 64'(evt_ready), 64'd1);
            end
        end
    end

    typedef struct {
        logic        valid;
        logic [1:0]  op;
        logic [31:0] data;
        logic        sready;
        logic        done;
        logic        exp_sv;
        logic        exp_er;
        logic [1:0]  exp_infl;
        logic [31:0] exp_cnt;
        logic        exp_err;
        logic        push;
    } vec_t;

    vec_t vecs[11];

    initial begin
        //           valid op     data       srdy done  sv    er    infl   cnt    err   push
        vecs[0]  = '{1'b1, 2'b00, 32'hA1,   1'b1, 1'b0, 1'b1, 1'b1, 2'd1, 32'd1, 1'b0, 1'b1};
        vecs[1]  = '{1'b1, 2'b01, 32'hA2,   1'b1, 1'b0, 1'b1, 1'b1, 2'd2, 32'd2, 1'b0, 1'b1};
        vecs[2]  = '{1'b1, 2'b00, 32'hA3,   1'b1, 1'b0, 1'b0, 1'b0, 2'd2, 32'd2, 1'b0, 1'b0};
        vecs[3]  = '{1'b1, 2'b00, 32'hA3,   1'b1, 1'b1, 1'b0, 1'b0, 2'd1, 32'd2, 1'b0, 1'b0};
        vecs[4]  = '{1'b1, 2'b00, 32'hA3,   1'b1, 1'b0, 1'b1, 1'b1, 2'd2, 32'd3, 1'b0, 1'b1};
        vecs[5]  = '{1'b0, 2'b00, 32'h0,    1'b1, 1'b1, 1'b0, 1'b0, 2'd1, 32'd3, 1'b0, 1'b0};
        vecs[6]  = '{1'b1, 2'b01, 32'hA4,   1'b1, 1'b1, 1'b1, 1'b1, 2'd1, 32'd4, 1'b0, 1'b1};
        vecs[7]  = '{1'b1, 2'b00, 32'hA5,   1'b0, 1'b0, 1'b1, 1'b0, 2'd1, 32'd4, 1'b0, 1'b0};
        vecs[8]  = '{1'b0, 2'b00, 32'h0,    1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 32'd4, 1'b0, 1'b0};
        vecs[9]  = '{1'b0, 2'b00, 32'h0,    1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 32'd4, 1'b1, 1'b0};
        vecs[10] = '{1'b0, 2'b00, 32'h0,    1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 32'd4, 1'b1, 1'b0};

        rst_n = 1'b0;
        drive(1'b0, 2'b00, '0, 1'b0, 1'b0);
        sweep_done = 1'b0; time_stable = 1'b0; online_req = 1'b0; clear_cnt = 1'b0;
        tick();
        tick();
        check("rst_seq_valid", 64'(seq_valid), 0);
        check("rst_evt_ready", 64'(evt_ready), 0);
        check("rst_inflight", 64'(inflight), 0);
        check("rst_spike_cnt", 64'(spike_cnt), 0);
        check("rst_sweep_cnt", 64'(sweep_cnt), 0);
        check("rst_err", 64'(err_uf), 0);
        check("rst_gnt", 64'(online_gnt), 0);
        rst_n = 1'b1;
        tick();

        // Spike flow control, in-flight limit, simultaneous inc/dec, underflow.
        for (int i = 0; i < 11; i++) begin
            drive(vecs[i].valid, vecs[i].op, vecs[i].data, vecs[i].sready, vecs[i].done);
            #1;
            check($sformatf("vec%0d_seq_valid", i), 64'(seq_valid), 64'(vecs[i].exp_sv));
            check($sformatf("vec%0d_evt_ready", i), 64'(evt_ready), 64'(vecs[i].exp_er));
            if (vecs[i].push) sb.push_back(vecs[i].data);
            tick();
            check($sformatf("vec%0d_inflight", i), 64'(inflight), 64'(vecs[i].exp_infl));
            check($sformatf("vec%0d_spike_cnt", i), 64'(spike_cnt), 64'(vecs[i].exp_cnt));
            check($sformatf("vec%0d_err", i), 64'(err_uf), 64'(vecs[i].exp_err));
        end

        // Sweep: drain two spikes, wait for stable time, issue, block spikes until done.
        drive(1'b1, 2'b00, 32'hB1, 1'b1, 1'b0); sb.push_back(32'hB1); tick();
        drive(1'b1, 2'b00, 32'hB2, 1'b1, 1'b0); sb.push_back(32'hB2); tick();
        check("sw_inflight2", 64'(inflight), 2);
        drive(1'b1, UPDATE_OP, 32'h5501, 1'b1, 1'b0); #1;
        check("sw_arrive_sv", 64'(seq_valid), 0);
        check("sw_arrive_er", 64'(evt_ready), 0);
        tick();
        spike_done = 1'b1; #1;
        check("sw_drain_sv", 64'(seq_valid), 0);
        tick();
        check("sw_drain_infl1", 64'(inflight), 1);
        tick();
        check("sw_drain_infl0", 64'(inflight), 0);
        spike_done = 1'b0; #1;
        check("sw_wait_time_sv", 64'(seq_valid), 0);
        tick();
        time_stable = 1'b1; #1;
        check("sw_time_ok_sv", 64'(seq_valid), 0);
        tick();
        seq_ready = 1'b0; #1;
        check("sw_issue_sv", 64'(seq_valid), 1);
        check("sw_issue_er_bp", 64'(evt_ready), 0);
        check("sw_issue_data", 64'(seq_data), 64'h5501);
        tick();
        seq_ready = 1'b1; sb.push_back(32'h5501); #1;
        check("sw_issue_er", 64'(evt_ready), 1);
        tick();
        drive(1'b1, 2'b01, 32'hC1, 1'b1, 1'b0); #1;
        check("sw_block_sv", 64'(seq_valid), 0);
        check("sw_block_er", 64'(evt_ready), 0);
        tick();
        check("sw_block2_sv", 64'(seq_valid), 0);
        check("sw_cnt_before", 64'(sweep_cnt), 0);
        sweep_done = 1'b1; #1;
        check("sw_done_sv", 64'(seq_valid), 0);
        tick();
        check("sw_cnt_after", 64'(sweep_cnt), 1);
        // Stray sweep_done while in PASS must not count.
        #1;
        check("sw_resume_sv", 64'(seq_valid), 1);
        check("sw_resume_er", 64'(evt_ready), 1);
        sb.push_back(32'hC1);
        tick();
        sweep_done = 1'b0;
        check("sw_stray_done_cnt", 64'(sweep_cnt), 1);
        check("sw_spike_cnt", 64'(spike_cnt), 7);
        check("sw_resume_infl", 64'(inflight), 1);

        // Online access: blocks spikes, grant two cycles after the last retire.
        online_req = 1'b1;
        drive(1'b1, 2'b00, 32'hC2, 1'b1, 1'b0); #1;
        check("ol_block_sv", 64'(seq_valid), 0);
        check("ol_gnt_busy", 64'(online_gnt), 0);
        tick();
        check("ol_gnt_busy2", 64'(online_gnt), 0);
        spike_done = 1'b1;
        tick();
        spike_done = 1'b0;
        check("ol_gnt_t1", 64'(online_gnt), 0);
        check("ol_infl0", 64'(inflight), 0);
        tick();
        check("ol_gnt_t2", 64'(online_gnt), 1);
        check("ol_granted_sv", 64'(seq_valid), 0);
        online_req = 1'b0; #1;
        check("ol_release_sv", 64'(seq_valid), 0);
        tick();
        check("ol_gnt_drop", 64'(online_gnt), 0);
        check("ol_flow_sv", 64'(seq_valid), 1);
        check("ol_flow_er", 64'(evt_ready), 1);
        sb.push_back(32'hC2);
        tick();
        check("ol_flow_infl", 64'(inflight), 1);
        check("ol_flow_cnt", 64'(spike_cnt), 8);

        // Reset in the middle of a sweep, then counter clear against a same-cycle accept.
        drive(1'b1, RST_OP, 32'h5502, 1'b1, 1'b1); #1;
        check("rs_arrive_sv", 64'(seq_valid), 0);
        tick();
        spike_done = 1'b0;
        tick();
        sb.push_back(32'h5502); #1;
        check("rs_issue_sv", 64'(seq_valid), 1);
        tick();
        evt_valid = 1'b0; #1;
        check("rs_sweep_sv", 64'(seq_valid), 0);
        rst_n = 1'b0; #1;
        check("rs_seq_valid", 64'(seq_valid), 0);
        check("rs_evt_ready", 64'(evt_ready), 0);
        check("rs_gnt", 64'(online_gnt), 0);
        check("rs_inflight", 64'(inflight), 0);
        check("rs_spike_cnt", 64'(spike_cnt), 0);
        check("rs_sweep_cnt", 64'(sweep_cnt), 0);
        check("rs_err", 64'(err_uf), 0);
        tick();
        rst_n = 1'b1;
        tick();
        sweep_done = 1'b1;
        tick();
        sweep_done = 1'b0;
        check("rs_late_done_cnt", 64'(sweep_cnt), 0);
        check("rs_late_done_infl", 64'(inflight), 0);
        drive(1'b1, 2'b00, 32'hD0, 1'b1, 1'b0); #1;
        check("rs_pass_sv", 64'(seq_valid), 1);
        sb.push_back(32'hD0);
        tick();
        check("rs_cnt1", 64'(spike_cnt), 1);
        drive(1'b1, 2'b01, 32'hD1, 1'b1, 1'b0); clear_cnt = 1'b1; #1;
        check("cl_accept_er", 64'(evt_ready), 1);
        sb.push_back(32'hD1);
        tick();
        clear_cnt = 1'b0; evt_valid = 1'b0;
        check("cl_spike_cnt", 64'(spike_cnt), 0);
        check("cl_inflight", 64'(inflight), 2);
        tick();
        check("sb_empty", 64'(sb.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
